fetch_unit: RTL and testbench

Program-counter and instruction-fetch sequencer for the 9-bit core. It drives the address into the combinational instruction ROM and receives the fetched word back the same cycle. From the control decoder it takes BranchEn; from the ALU it takes the equality flag. Each cycle it chooses the next PC: sequential, branch target, or hold. It also owns run/halt sequencing and a retired-instruction counter.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_branch_lut.sv | 19 +
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the fetch sequencer
package definitions;

  // Halt encoding: the all-ones instruction word
  localparam logic [8:0] kHALT = 9'h1FF;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Absolute branch targets indexed by Instruction[3:0].
  // Entries may be wider than the PC; only the low bits are used.
  localparam logic [15:0] kBR_LUT [16] = '{
    16'h0000, 16'h0020, 16'h0030, 16'h0040,
    16'h0080, 16'h0100, 16'h0200, 16'h03FF,
    16'h0005, 16'h0010, 16'h0155, 16'h02AA,
    16'h03F0, 16'h07C1, 16'hFFFE, 16'h0123
  };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// rtl/fetch_unit_branch_lut.sv - combinational branch target lookup
module branch_lut
  import definitions::*;
#(
  parameter int PC_W = 10
) (
  input  logic [3:0]      index,
  output logic [PC_W-1:0] target
);

  logic [15:0] entry;

  // Pick the table entry and fit it to the PC width (low bits kept)
  always_comb begin
    entry  = kBR_LUT[index];
    target = PC_W'(entry);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, run/halt sequencing and retire counter
module fetch_unit
  import definitions::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic [8:0]       Instruction,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic             Stall,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             InstrValid,
  output logic             Done,
  output logic [CNT_W-1:0] RetireCnt
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  br_target;

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .index  (Instruction[3:0]),
    .target (br_target)
  );

  // State, PC, counter and Done registers; reset is asynchronous
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state, next-PC and retire decision; Start overrides everything
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    InstrValid = 1'b0;

    if (Start) begin
      state_d = RUN;
      pc_d    = StartAddr;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (!Stall) begin
            if (Instruction == kHALT) begin
              state_d = HALTED;
              done_d  = 1'b1;
            end else begin
              InstrValid = 1'b1;
              // Counter sticks at all-ones rather than wrapping
              if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
              if (BranchEn && Taken) begin
                pc_d = br_target;
              end else begin
                pc_d = pc_q + PC_W'(1);
              end
            end
          end
        end
        HALTED: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ProgCtr   = pc_q;
  assign Done      = done_q;
  assign RetireCnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [9:0]  StartAddr;
  logic [8:0]  Instruction;
  logic        BranchEn;
  logic        Taken;
  logic        Stall;
  logic [9:0]  ProgCtr;
  logic        InstrValid;
  logic        Done;
  logic [15:0] RetireCnt;

  int n_vec;
  int n_err;

  fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Instruction (Instruction),
    .BranchEn    (BranchEn),
    .Taken       (Taken),
    .Stall       (Stall),
    .ProgCtr     (ProgCtr),
    .InstrValid  (InstrValid),
    .Done        (Done),
    .RetireCnt   (RetireCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        start;
    logic [9:0]  addr;
    logic [8:0]  instr;
    logic        be;
    logic        tk;
    logic        stall;
    logic        exp_valid;
    logic [9:0]  exp_pc;
    logic        exp_done;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic start, input logic [9:0] addr,
                     input logic [8:0] instr, input logic be, input logic tk,
                     input logic stall, input logic exp_valid, input logic [9:0] exp_pc,
                     input logic exp_done, input logic [15:0] exp_cnt);
    vec_t v;
    v.name = name; v.start = start; v.addr = addr; v.instr = instr;
    v.be = be; v.tk = tk; v.stall = stall; v.exp_valid = exp_valid;
    v.exp_pc = exp_pc; v.exp_done = exp_done; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] a, input logic [8:0] i,
                       input logic be, input logic tk, input logic st);
    Start = s; StartAddr = a; Instruction = i; BranchEn = be; Taken = tk; Stall = st;
  endtask

  // Inputs change at posedge+1; InstrValid sampled 1ns later, registers after next posedge+1
  task automatic apply(input vec_t v);
    drive(v.start, v.addr, v.instr, v.be, v.tk, v.stall);
    #1;
    chk({v.name, ".valid"}, 32'(InstrValid), 32'(v.exp_valid));
    @(posedge Clk);
    #1;
    chk({v.name, ".pc"},   32'(ProgCtr),   32'(v.exp_pc));
    chk({v.name, ".done"}, 32'(Done),      32'(v.exp_done));
    chk({v.name, ".cnt"},  32'(RetireCnt), 32'(v.exp_cnt));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset_n = 1'b0;
    drive(1'b0, 10'h0, 9'h000, 1'b0, 1'b0, 1'b0);

    //   name        st  addr    instr   be  tk  stl  vld  pc      done cnt
    add("idle",      0, 10'h000, 9'h000, 0, 0, 0,  0, 10'h000, 0, 16'd0);
    add("start5",    1, 10'h005, 9'h000, 0, 0, 0,  0, 10'h005, 0, 16'd0);
    add("seq1",      0, 10'h000, 9'h000, 0, 0, 0,  1, 10'h006, 0, 16'd1);
    add("seq2",      0, 10'h000, 9'h000, 0, 0, 0,  1, 10'h007, 0, 16'd2);
    add("seq3",      0, 10'h000, 9'h000, 0, 0, 0,  1, 10'h008, 0, 16'd3);
    add("start10",   1, 10'h010, 9'h000, 0, 0, 0,  0, 10'h010, 0, 16'd0);
    add("br_taken",  0, 10'h000, 9'h003, 1, 1, 0,  1, 10'h040, 0, 16'd1);
    add("start10b",  1, 10'h010, 9'h000, 0, 0, 0,  0, 10'h010, 0, 16'd0);
    add("br_ntaken", 0, 10'h000, 9'h003, 1, 0, 0,  1, 10'h011, 0, 16'd1);
    add("tk_no_be",  0, 10'h000, 9'h003, 0, 1, 0,  1, 10'h012, 0, 16'd2);
    add("br_trunc",  0, 10'h000, 9'h00D, 1, 1, 0,  1, 10'h3C1, 0, 16'd3);
    add("br_trunc2", 0, 10'h000, 9'h00E, 1, 1, 0,  1, 10'h3FE, 0, 16'd4);
    add("start20",   1, 10'h020, 9'h000, 0, 0, 0,  0, 10'h020, 0, 16'd0);
    add("stall1",    0, 10'h000, 9'h000, 0, 0, 1,  0, 10'h020, 0, 16'd0);
    add("stall2",    0, 10'h000, 9'h003, 1, 1, 1,  0, 10'h020, 0, 16'd0);
    add("stall3",    0, 10'h000, 9'h1FF, 0, 0, 1,  0, 10'h020, 0, 16'd0);
    add("stall4",    0, 10'h000, 9'h000, 0, 0, 1,  0, 10'h020, 0, 16'd0);
    add("unstall",   0, 10'h000, 9'h000, 0, 0, 0,  1, 10'h021, 0, 16'd1);
    add("start3ff",  1, 10'h3FF, 9'h000, 0, 0, 0,  0, 10'h3FF, 0, 16'd0);
    add("wrap",      0, 10'h000, 9'h0A5, 0, 0, 0,  1, 10'h000, 0, 16'd1);
    add("halt",      0, 10'h000, 9'h1FF, 0, 0, 0,  0, 10'h000, 1, 16'd1);
    add("halted1",   0, 10'h000, 9'h000, 0, 0, 0,  0, 10'h000, 1, 16'd1);
    add("halted2",   0, 10'h000, 9'h003, 1, 1, 1,  0, 10'h000, 1, 16'd1);
    add("restart",   1, 10'h100, 9'h1FF, 0, 0, 0,  0, 10'h100, 0, 16'd0);
    add("run100",    0, 10'h000, 9'h000, 0, 0, 0,  1, 10'h101, 0, 16'd1);
    add("st_stall",  1, 10'h200, 9'h000, 0, 0, 1,  0, 10'h200, 0, 16'd0);
    add("run200",    0, 10'h000, 9'h000, 0, 0, 0,  1, 10'h201, 0, 16'd1);

    // Reset values, checked while reset is held
    #13;
    chk("reset.pc",    32'(ProgCtr),    32'h0);
    chk("reset.done",  32'(Done),       32'h0);
    chk("reset.cnt",   32'(RetireCnt),  32'h0);
    chk("reset.valid", 32'(InstrValid), 32'h0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-RUN, between clock edges
    drive(1'b0, 10'h0, 9'h000, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("areset.pc",    32'(ProgCtr),    32'h0);
    chk("areset.cnt",   32'(RetireCnt),  32'h0);
    chk("areset.done",  32'(Done),       32'h0);
    chk("areset.valid", 32'(InstrValid), 32'h0);
    #2;
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      #1;
      chk("post_reset_idle.valid", 32'(InstrValid), 32'h0);
      chk("post_reset_idle.pc",    32'(ProgCtr),    32'h0);
    end
    apply('{"post_reset_start", 1'b1, 10'h030, 9'h000, 1'b0, 1'b0, 1'b0,
            1'b0, 10'h030, 1'b0, 16'd0});
    apply('{"post_reset_run", 1'b0, 10'h000, 9'h000, 1'b0, 1'b0, 1'b0,
            1'b1, 10'h031, 1'b0, 16'd1});

    // Counter saturation: 65538 retirements from PC 0
    drive(1'b1, 10'h000, 9'h000, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (65535) @(posedge Clk);
    #1;
    chk("sat.reach", 32'(RetireCnt), 32'hFFFF);
    repeat (3) @(posedge Clk);
    #1;
    chk("sat.hold",  32'(RetireCnt),  32'hFFFF);
    chk("sat.pc",    32'(ProgCtr),    32'h002);
    chk("sat.valid", 32'(InstrValid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
